vga_timing_gen: RTL



---
 rtl/vga_timing_gen_if.sv | 29 ++
 rtl/vga_timing_gen.sv | 131 +++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel strobe in from the clock divider, sync/position/pulses out to the renderer.
// Handshake: no valid/ready; pix_en is a one-clk strobe and every output is a registered level or one-clk pulse.
interface vga_timing_gen_if #(
    parameter int XW = 10,
    parameter int YW = 10
);
    logic          pix_en;
    logic          hsync_n;
    logic          vsync_n;
    logic          active;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          line_start;
    logic          frame_start;
    logic [1:0]    dbg_hstate;
    logic [1:0]    dbg_vstate;

    modport master (
        input  pix_en,
        output hsync_n, vsync_n, active, x, y, line_start, frame_start,
        output dbg_hstate, dbg_vstate
    );

    modport slave (
        output pix_en,
        input  hsync_n, vsync_n, active, x, y, line_start, frame_start,
        input  dbg_hstate, dbg_vstate
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: horizontal/vertical counters with porch/sync FSMs, outputs registered per pix_en.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int XW       = 10,
    parameter int YW       = 10
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [XW-1:0] H_LAST    = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_FP_AT   = XW'(H_ACTIVE);
    localparam logic [XW-1:0] H_SYNC_AT = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] H_BP_AT   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_LAST    = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_FP_AT   = YW'(V_ACTIVE);
    localparam logic [YW-1:0] V_SYNC_AT = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] V_BP_AT   = YW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {ST_H_ACT, ST_H_FP, ST_H_SYNC, ST_H_BP} h_state_t;
    typedef enum logic [1:0] {ST_V_ACT, ST_V_FP, ST_V_SYNC, ST_V_BP} v_state_t;

    logic [XW-1:0] r_hcount;
    logic [YW-1:0] r_vcount;
    h_state_t      r_hstate;
    v_state_t      r_vstate;

    logic          r_hsync_n;
    logic          r_vsync_n;
    logic          r_active;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_line_start;
    logic          r_frame_start;

    logic [XW-1:0] w_hcount_nxt;
    logic [YW-1:0] w_vcount_nxt;
    h_state_t      w_hstate_nxt;
    v_state_t      w_vstate_nxt;
    logic          w_h_wrap;
    logic          w_active;

    // Each FSM leaves a region when the freshly advanced count lands on the next region's first position.
    always_comb begin
        w_h_wrap     = (r_hcount == H_LAST);
        w_hcount_nxt = w_h_wrap ? '0 : r_hcount + 1'b1;
        w_vcount_nxt = r_vcount;
        if (w_h_wrap) begin
            w_vcount_nxt = (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
        end

        w_hstate_nxt = r_hstate;
        case (r_hstate)
            ST_H_ACT:  if (w_hcount_nxt == H_FP_AT)   w_hstate_nxt = ST_H_FP;
            ST_H_FP:   if (w_hcount_nxt == H_SYNC_AT) w_hstate_nxt = ST_H_SYNC;
            ST_H_SYNC: if (w_hcount_nxt == H_BP_AT)   w_hstate_nxt = ST_H_BP;
            ST_H_BP:   if (w_hcount_nxt == '0)        w_hstate_nxt = ST_H_ACT;
            default:   w_hstate_nxt = ST_H_ACT;
        endcase

        w_vstate_nxt = r_vstate;
        case (r_vstate)
            ST_V_ACT:  if (w_h_wrap && w_vcount_nxt == V_FP_AT)   w_vstate_nxt = ST_V_FP;
            ST_V_FP:   if (w_h_wrap && w_vcount_nxt == V_SYNC_AT) w_vstate_nxt = ST_V_SYNC;
            ST_V_SYNC: if (w_h_wrap && w_vcount_nxt == V_BP_AT)   w_vstate_nxt = ST_V_BP;
            ST_V_BP:   if (w_h_wrap && w_vcount_nxt == '0)        w_vstate_nxt = ST_V_ACT;
            default:   w_vstate_nxt = ST_V_ACT;
        endcase

        w_active = (r_hstate == ST_H_ACT) && (r_vstate == ST_V_ACT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_hstate <= ST_H_ACT;
            r_vstate <= ST_V_ACT;
        end else if (bus.pix_en) begin
            r_hcount <= w_hcount_nxt;
            r_vcount <= w_vcount_nxt;
            r_hstate <= w_hstate_nxt;
            r_vstate <= w_vstate_nxt;
        end
    end

    // Outputs describe the position being consumed on this strobe, not the advanced one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hsync_n     <= 1'b1;
            r_vsync_n     <= 1'b1;
            r_active      <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (bus.pix_en) begin
                r_hsync_n     <= (r_hstate != ST_H_SYNC);
                r_vsync_n     <= (r_vstate != ST_V_SYNC);
                r_active      <= w_active;
                r_x           <= w_active ? r_hcount : '0;
                r_y           <= w_active ? r_vcount : '0;
                r_line_start  <= (r_hcount == '0);
                r_frame_start <= (r_hcount == '0) && (r_vcount == '0);
            end
        end
    end

    assign bus.hsync_n     = r_hsync_n;
    assign bus.vsync_n     = r_vsync_n;
    assign bus.active      = r_active;
    assign bus.x           = r_x;
    assign bus.y           = r_y;
    assign bus.line_start  = r_line_start;
    assign bus.frame_start = r_frame_start;
    assign bus.dbg_hstate  = r_hstate;
    assign bus.dbg_vstate  = r_vstate;
endmodule
